// File: rtl/pool_stream_multi.sv
`default_nettype none
// ============================================================================
// Module      : pool_stream_multi
// Description : Streaming multi-channel average/max pooling over WINDOW beats,
//               valid/ready on both sides, reciprocal-multiply averaging.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_stream_multi #(
    parameter int DATAWIDTH     = 16,
    parameter int CHANNEL_COUNT = 4,
    parameter int WINDOW        = 169,
    parameter int RECIP_FRAC    = 16,
    parameter int RECIP         = 388,
    localparam int ACCW         = DATAWIDTH + $clog2(WINDOW) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mode_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CHANNEL_COUNT*DATAWIDTH-1:0] in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CHANNEL_COUNT*DATAWIDTH-1:0] avg_out,
    output logic [CHANNEL_COUNT*ACCW-1:0]      sum_out,
    output logic                               finished
);
    localparam int CNTW = $clog2(WINDOW + 1);
    localparam int PW   = ACCW + RECIP_FRAC + 2;

    localparam logic [CNTW-1:0]      c_last   = CNTW'(WINDOW - 1);
    localparam logic signed [PW-1:0] c_recip  = PW'(RECIP);
    localparam logic signed [PW-1:0] c_half   = PW'(64'd1 << (RECIP_FRAC - 1));
    localparam logic signed [PW-1:0] c_sat_hi = {{(PW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] c_sat_lo = {{(PW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SCALE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNTW-1:0]        r_count;
    logic                   r_mode;
    logic                   w_accept;
    logic                   w_beat;
    logic                   w_hs;
    logic signed [ACCW-1:0] r_acc [CHANNEL_COUNT];
    logic signed [ACCW-1:0] w_x   [CHANNEL_COUNT];
    logic [DATAWIDTH-1:0]   w_res [CHANNEL_COUNT];

    // Handshake qualifiers are forced low while reset is asserted.
    assign w_accept  = !rst && (r_state == S_IDLE || r_state == S_ACCUM);
    assign in_ready  = w_accept;
    assign out_valid = !rst && (r_state == S_HOLD);
    assign w_beat    = in_valid && w_accept;
    assign w_hs      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_beat) w_state_next = (WINDOW == 1) ? S_SCALE : S_ACCUM;
            S_ACCUM: if (w_beat && r_count == c_last) w_state_next = S_SCALE;
            S_SCALE: w_state_next = S_HOLD;
            S_HOLD:  if (w_hs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    generate
        for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
            logic signed [PW-1:0] w_prod;
            logic signed [PW-1:0] w_rnd;

            assign w_x[c]  = {{(ACCW-DATAWIDTH){in_data[c*DATAWIDTH+DATAWIDTH-1]}},
                              in_data[c*DATAWIDTH +: DATAWIDTH]};
            // Product always fits in PW bits, so truncation is exact.
            assign w_prod  = $signed({{(PW-ACCW){r_acc[c][ACCW-1]}}, r_acc[c]}) * c_recip;
            assign w_rnd   = (w_prod + c_half) >>> RECIP_FRAC;
            assign w_res[c] = r_mode              ? r_acc[c][DATAWIDTH-1:0] :
                              (w_rnd > c_sat_hi)  ? c_sat_hi[DATAWIDTH-1:0] :
                              (w_rnd < c_sat_lo)  ? c_sat_lo[DATAWIDTH-1:0] :
                                                    w_rnd[DATAWIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_mode   <= 1'b0;
            avg_out  <= '0;
            sum_out  <= '0;
            finished <= 1'b0;
            for (int c = 0; c < CHANNEL_COUNT; c++) r_acc[c] <= '0;
        end else begin
            finished <= w_hs;
            case (r_state)
                S_IDLE: begin
                    if (w_beat) begin
                        r_mode  <= mode_in;
                        r_count <= CNTW'(1);
                        for (int c = 0; c < CHANNEL_COUNT; c++) r_acc[c] <= w_x[c];
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_count <= r_count + CNTW'(1);
                        for (int c = 0; c < CHANNEL_COUNT; c++) begin
                            if (!r_mode)              r_acc[c] <= r_acc[c] + w_x[c];
                            else if (w_x[c] > r_acc[c]) r_acc[c] <= w_x[c];
                        end
                    end
                end
                S_SCALE: begin
                    for (int c = 0; c < CHANNEL_COUNT; c++) begin
                        avg_out[c*DATAWIDTH +: DATAWIDTH] <= w_res[c];
                        sum_out[c*ACCW +: ACCW]           <= r_acc[c];
                    end
                end
                S_HOLD: begin
                    if (w_hs) begin
                        r_count <= '0;
                        for (int c = 0; c < CHANNEL_COUNT; c++) r_acc[c] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pool_stream_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_stream_multi
// Description : Table-driven and randomized self-checking bench for pool_stream_multi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_stream_multi;
    localparam int DW = 16, CH = 2, WIN = 4, RF = 16, RC = 16384, AW = 19;
    localparam int RC8 = 17000, AW8 = 11;
    localparam int NV = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode_in = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CH*DW-1:0] in_data = '0;
    logic           in_ready, out_valid, finished;
    logic [CH*DW-1:0] avg_out;
    logic [CH*AW-1:0] sum_out;

    logic           e_mode = 1'b0, e_valid = 1'b0, e_oready = 1'b0;
    logic [7:0]     e_data = '0;
    logic           e_ready, e_ovalid, e_fin;
    logic [7:0]     e_avg;
    logic [AW8-1:0] e_sum;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pool_stream_multi #(.DATAWIDTH(DW), .CHANNEL_COUNT(CH), .WINDOW(WIN),
                        .RECIP_FRAC(RF), .RECIP(RC)) dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .avg_out(avg_out), .sum_out(sum_out), .finished(finished));

    pool_stream_multi #(.DATAWIDTH(8), .CHANNEL_COUNT(1), .WINDOW(WIN),
                        .RECIP_FRAC(RF), .RECIP(RC8)) dut8 (
        .clk(clk), .rst(rst), .mode_in(e_mode), .in_valid(e_valid), .in_ready(e_ready),
        .in_data(e_data), .out_valid(e_ovalid), .out_ready(e_oready),
        .avg_out(e_avg), .sum_out(e_sum), .finished(e_fin));

    typedef struct {
        logic   mode;
        int     d[8];      // beat b, channel c at index b*2+c
        int     gap;
        int     stall;
        longint es[2];
        longint ea[2];
    } vec_t;

    vec_t tbl[NV];

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Rounded average from the definition, then clamp to the signed output range.
    function automatic longint ref_avg(input longint s, input longint recip, input int dw);
        longint r  = floor_div(s * recip + (64'sd1 <<< (RF - 1)), 64'sd1 <<< RF);
        longint hi = (64'sd1 <<< (dw - 1)) - 1;
        longint lo = -hi - 1;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        for (int c = 0; c < 2; c++) begin
            longint sm = 0;
            longint mx = v.d[c];
            for (int b = 0; b < WIN; b++) begin
                sm += v.d[b*2+c];
                if (v.d[b*2+c] > mx) mx = v.d[b*2+c];
            end
            r.es[c] = v.mode ? mx : sm;
            r.ea[c] = v.mode ? mx : ref_avg(sm, RC, DW);
        end
        return r;
    endfunction

    function automatic longint sumc(input int c);
        return longint'($signed(sum_out[c*AW +: AW]));
    endfunction

    function automatic longint avgc(input int c);
        return longint'($signed(avg_out[c*DW +: DW]));
    endfunction

    task automatic do_beat(input int a0, input int a1, input logic m);
        int tries = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = {16'(a1), 16'(a0)};
        mode_in   = m;
        out_ready = 1'($urandom_range(0, 1));
        while (!in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Entered 1ns after the edge that accepted the last beat of a window.
    task automatic finish_window(input string tag, input longint es0, input longint es1,
                                 input longint ea0, input longint ea1, input int stall);
        out_ready = 1'b0;
        check({tag, "_valid_T1"}, out_valid, 0);
        check({tag, "_ready_T1"}, in_ready, 0);
        @(posedge clk); #1;
        check({tag, "_valid_T2"}, out_valid, 1);
        check({tag, "_fin_T2"}, finished, 0);
        check({tag, "_sum0"}, sumc(0), es0);
        check({tag, "_sum1"}, sumc(1), es1);
        check({tag, "_avg0"}, avgc(0), ea0);
        check({tag, "_avg1"}, avgc(1), ea1);
        repeat (stall) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, in_ready, 0);
            check({tag, "_hold_avg0"}, avgc(0), ea0);
            check({tag, "_hold_sum1"}, sumc(1), es1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_fin_pulse"}, finished, 1);
        check({tag, "_valid_clr"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
        @(posedge clk); #1;
        check({tag, "_fin_drop"}, finished, 0);
    endtask

    task automatic run8(input string tag, input int v0, input int v1, input int v2, input int v3);
        int v[4];
        longint sm;
        v = '{v0, v1, v2, v3};
        sm = longint'(v0) + v1 + v2 + v3;
        for (int b = 0; b < 4; b++) begin
            int tries = 0;
            @(negedge clk);
            e_valid = 1'b1;
            e_data  = 8'(v[b]);
            while (!e_ready && tries < 20) begin
                @(negedge clk);
                tries++;
            end
            check({tag, "_ready_wait"}, e_ready, 1);
            @(posedge clk);
            #1 e_valid = 1'b0;
        end
        check({tag, "_valid_T1"}, e_ovalid, 0);
        @(posedge clk); #1;
        check({tag, "_valid_T2"}, e_ovalid, 1);
        check({tag, "_sum"}, longint'($signed(e_sum)), sm);
        check({tag, "_avg"}, longint'($signed(e_avg)), ref_avg(sm, RC8, 8));
        @(negedge clk);
        e_oready = 1'b1;
        @(posedge clk); #1;
        e_oready = 1'b0;
        check({tag, "_fin"}, e_fin, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0].mode = 1'b0; tbl[0].d = '{1, -4, 2, -4, 3, -4, 4, -4};
        tbl[0].gap = 0; tbl[0].stall = 0;
        tbl[0].es = '{10, -16}; tbl[0].ea = '{3, -4};
        tbl[1].mode = 1'b1; tbl[1].d = '{-5, -9, 7, -8, -2, -7, 3, -6};
        tbl[1].gap = 0; tbl[1].stall = 0;
        tbl[1].es = '{7, -6}; tbl[1].ea = '{7, -6};
        tbl[2] = tbl[0]; tbl[2].stall = 5;
        tbl[3].mode = 1'b0; tbl[3].d = '{-32768, 32767, -32768, 32767, -32768, 32767, -32768, 32767};
        tbl[3].gap = 1; tbl[3].stall = 1;
        tbl[3] = model(tbl[3]);
        for (int k = 4; k < NV; k++) begin
            tbl[k].mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) tbl[k].d[i] = int'($urandom_range(0, 65535)) - 32768;
            tbl[k].gap   = int'($urandom_range(0, 2));
            tbl[k].stall = int'($urandom_range(0, 3));
            tbl[k] = model(tbl[k]);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_finished", finished, 0);
        check("rst_sum0", sumc(0), 0);
        check("rst_avg1", avgc(1), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", in_ready, 1);

        for (int k = 0; k < NV; k++) begin
            for (int b = 0; b < WIN; b++) begin
                do_beat(tbl[k].d[b*2], tbl[k].d[b*2+1],
                        (b == 0) ? tbl[k].mode : 1'($urandom_range(0, 1)));
                if (b < WIN - 1) repeat (tbl[k].gap) @(posedge clk);
            end
            finish_window($sformatf("tbl%0d", k), tbl[k].es[0], tbl[k].es[1],
                          tbl[k].ea[0], tbl[k].ea[1], tbl[k].stall);
        end

        // Alternating bubbles with mode_in flipping after the first beat
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_data  = {16'(-1), 16'(2 * (i / 2 + 1))};
            mode_in  = (i >= 1);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        finish_window("bubble", 20, -4, 5, -1, 0);

        // Reset after two beats discards the partial window
        do_beat(99, 99, 1'b1);
        do_beat(99, 99, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1 check("midrst_ready", in_ready, 0);
        @(posedge clk); #1;
        check("midrst_fin", finished, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_sum0", sumc(0), 0);
        check("midrst_avg0", avgc(0), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < WIN; b++) do_beat(10, 10, 1'b0);
        finish_window("after_rst", 40, 40, 10, 10, 0);

        // Saturation on the 8-bit instance, then random 8-bit windows
        run8("sat_pos", 127, 127, 127, 127);
        run8("sat_neg", -128, -128, -128, -128);
        for (int k = 0; k < 4; k++)
            run8($sformatf("r8_%0d", k), int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
